// File: rtl/vga_fb_reader.sv
// Pixel-side framebuffer scanner: upscales a low-res RRRGGGBB framebuffer to the
// visible raster, with a colour-bar fallback and syncs delayed to match rgb.
module vga_fb_reader #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned FB_W        = 160,
    parameter int unsigned AW          = 15,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic          pixel_clk,
    input  logic          rst_n,
    input  logic [10:0]   hcount,
    input  logic [10:0]   vcount,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic          vblank_in,
    input  logic          fb_en,
    output logic [AW-1:0] fb_addr,
    output logic          fb_rd,
    input  logic [7:0]    fb_data,
    output logic [7:0]    rgb,
    output logic          hs_out,
    output logic          vs_out,
    output logic          vblank_out,
    output logic          frame_pulse,
    output logic [7:0]    frame_cnt
);

    localparam int unsigned CW = 11;
    localparam logic [CW-1:0] ROW_MASK = CW'((1 << SCALE_SHIFT) - 1);

    logic [AW-1:0] line_base;
    logic          mode;

    // Index 0 is stage 1 (aligned with fb_addr); index RD_LAT aligns with fb_data.
    logic [RD_LAT:0] act_pipe;
    logic [RD_LAT:0] mode_pipe;
    logic [2:0]      bar_pipe [RD_LAT+1];

    logic [RD_LAT:0] hs_pipe;
    logic [RD_LAT:0] vs_pipe;
    logic [RD_LAT:0] vb_pipe;

    logic            active_c;
    logic            frame_start_c;
    logic            mode_next_c;
    logic            line_end_c;
    logic [AW-1:0]   pix_addr_c;

    function automatic logic [7:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 8'hFF;
            3'd1:    bar_colour = 8'hFC;
            3'd2:    bar_colour = 8'h1F;
            3'd3:    bar_colour = 8'h1C;
            3'd4:    bar_colour = 8'hE3;
            default: bar_colour = 8'h00;
        endcase
    endfunction

    // The first pixel of a frame already uses the newly sampled mode.
    always_comb begin
        active_c      = (hcount < CW'(H_ACTIVE)) && (vcount < CW'(V_ACTIVE));
        frame_start_c = (hcount == '0) && (vcount == '0);
        mode_next_c   = frame_start_c ? fb_en : mode;
        line_end_c    = (hcount == CW'(H_ACTIVE)) && (vcount < CW'(V_ACTIVE)) &&
                        ((vcount & ROW_MASK) == ROW_MASK);
        pix_addr_c    = line_base + AW'(hcount >> SCALE_SHIFT);
    end

    // Address generation: line_base advances one fb row every 2^SCALE_SHIFT lines.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            line_base <= '0;
            fb_addr   <= '0;
        end else begin
            if (vcount >= CW'(V_ACTIVE)) begin
                line_base <= '0;
            end else if (line_end_c) begin
                line_base <= line_base + AW'(FB_W);
            end
            if (active_c) begin
                fb_addr <= pix_addr_c;
            end
        end
    end

    // Frame-start bookkeeping and mode latch.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode        <= 1'b0;
            frame_pulse <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            mode        <= mode_next_c;
            frame_pulse <= frame_start_c;
            if (frame_start_c) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // Pixel flags travel alongside the RAM read.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            act_pipe  <= '0;
            mode_pipe <= '0;
            for (int i = 0; i <= int'(RD_LAT); i++) begin
                bar_pipe[i] <= '0;
            end
        end else begin
            act_pipe    <= {act_pipe[RD_LAT-1:0], active_c};
            mode_pipe   <= {mode_pipe[RD_LAT-1:0], mode_next_c};
            bar_pipe[0] <= hcount[9:7];
            for (int i = 1; i <= int'(RD_LAT); i++) begin
                bar_pipe[i] <= bar_pipe[i-1];
            end
        end
    end

    // Colour select.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb <= '0;
        end else if (!act_pipe[RD_LAT]) begin
            rgb <= '0;
        end else if (mode_pipe[RD_LAT]) begin
            rgb <= fb_data;
        end else begin
            rgb <= bar_colour(bar_pipe[RD_LAT]);
        end
    end

    // Sync inputs already lag the counters by one, so RD_LAT+1 stages align them with rgb.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_pipe <= '1;
            vs_pipe <= '1;
            vb_pipe <= '0;
        end else begin
            hs_pipe <= {hs_pipe[RD_LAT-1:0], hs_in};
            vs_pipe <= {vs_pipe[RD_LAT-1:0], vs_in};
            vb_pipe <= {vb_pipe[RD_LAT-1:0], vblank_in};
        end
    end

    assign fb_rd      = act_pipe[0];
    assign hs_out     = hs_pipe[RD_LAT];
    assign vs_out     = vs_pipe[RD_LAT];
    assign vblank_out = vb_pipe[RD_LAT];

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench for vga_fb_reader: two instances (RD_LAT=1 and RD_LAT=3) share
// the counter stimulus; each has its own RAM model returning addr[7:0].
module tb_vga_fb_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hs_in;
    logic        vs_in;
    logic        vblank_in;
    logic        fb_en;

    logic [14:0] fb_addr_a, fb_addr_b;
    logic        fb_rd_a, fb_rd_b;
    logic [7:0]  fb_data_a, fb_data_b;
    logic [7:0]  rgb_a, rgb_b;
    logic        hs_out_a, hs_out_b, vs_out_a, vs_out_b, vb_out_a, vb_out_b;
    logic        fp_a, fp_b;
    logic [7:0]  fcnt_a, fcnt_b;

    logic [7:0]  ram_a;
    logic [7:0]  ram_b [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Timing-controller style registered syncs (active-low hsync/vsync).
    always_ff @(posedge clk) begin
        hs_in     <= !(hcount >= 11'd656 && hcount < 11'd752);
        vs_in     <= !(vcount >= 11'd490 && vcount < 11'd492);
        vblank_in <= (vcount >= 11'd480);
    end

    always_ff @(posedge clk) begin
        ram_a    <= fb_addr_a[7:0];
        ram_b[0] <= fb_addr_b[7:0];
        ram_b[1] <= ram_b[0];
        ram_b[2] <= ram_b[1];
    end
    assign fb_data_a = ram_a;
    assign fb_data_b = ram_b[2];

    vga_fb_reader #(.RD_LAT(1)) dut_a (
        .pixel_clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
        .hs_in(hs_in), .vs_in(vs_in), .vblank_in(vblank_in), .fb_en(fb_en),
        .fb_addr(fb_addr_a), .fb_rd(fb_rd_a), .fb_data(fb_data_a), .rgb(rgb_a),
        .hs_out(hs_out_a), .vs_out(vs_out_a), .vblank_out(vb_out_a),
        .frame_pulse(fp_a), .frame_cnt(fcnt_a)
    );

    vga_fb_reader #(.RD_LAT(3)) dut_b (
        .pixel_clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
        .hs_in(hs_in), .vs_in(vs_in), .vblank_in(vblank_in), .fb_en(fb_en),
        .fb_addr(fb_addr_b), .fb_rd(fb_rd_b), .fb_data(fb_data_b), .rgb(rgb_b),
        .hs_out(hs_out_b), .vs_out(vs_out_b), .vblank_out(vb_out_b),
        .frame_pulse(fp_b), .frame_cnt(fcnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait for the next edge to consume the current counters, then present new ones.
    task automatic cyc(input int h, input int v);
        @(posedge clk);
        #1;
        hcount = 11'(h);
        vcount = 11'(v);
    endtask

    // After show(h,v) the RD_LAT=1 rgb/syncs reflect (h,v); fb_addr/fb_rd reflect (h+2,v).
    task automatic show(input int h, input int v);
        for (int k = 0; k < 4; k++) cyc(h + k, v);
    endtask

    initial begin
        rst_n  = 1'b0;
        hcount = '0;
        vcount = '0;
        fb_en  = 1'b1;
        cyc(0, 0);
        cyc(0, 0);
        cyc(0, 0);
        chk("rst_rgb", 32'(rgb_a), 32'h00);
        chk("rst_hs", 32'(hs_out_a), 32'h1);
        chk("rst_vs", 32'(vs_out_a), 32'h1);
        chk("rst_vblank", 32'(vb_out_a), 32'h0);
        chk("rst_fb_addr", 32'(fb_addr_a), 32'h0);
        chk("rst_fb_rd", 32'(fb_rd_a), 32'h0);
        chk("rst_frame_cnt", 32'(fcnt_a), 32'h0);
        chk("rst_frame_pulse", 32'(fp_a), 32'h0);
        rst_n = 1'b1;

        // First frame, framebuffer mode: addresses and data latency.
        for (int h = 1; h < 12; h++) begin
            cyc(h, 0);
            if (h == 1) begin
                chk("fs_pulse_hi", 32'(fp_a), 32'h1);
                chk("fs_cnt_1", 32'(fcnt_a), 32'd1);
            end
            if (h == 2) chk("fs_pulse_lo", 32'(fp_a), 32'h0);
            chk("scan_fb_addr", 32'(fb_addr_a), 32'((h - 1) >> 2));
            chk("scan_fb_rd", 32'(fb_rd_a), 32'h1);
            if (h >= 3) chk("scan_rgb_lat1", 32'(rgb_a), 32'((h - 3) >> 2));
            if (h >= 5) chk("scan_rgb_lat3", 32'(rgb_b), 32'((h - 5) >> 2));
        end

        // line_base stepping and the last visible pixel.
        cyc(639, 3);
        cyc(640, 3);
        cyc(0, 4);
        cyc(1, 4);
        chk("row4_fb_addr", 32'(fb_addr_a), 32'd160);
        for (int v = 7; v < 476; v += 4) cyc(640, v);
        cyc(639, 479);
        cyc(640, 479);
        chk("last_fb_addr", 32'(fb_addr_a), 32'd19199);
        chk("last_fb_rd", 32'(fb_rd_a), 32'h1);
        cyc(0, 480);
        chk("vblank_fb_rd", 32'(fb_rd_a), 32'h0);
        chk("vblank_addr_hold", 32'(fb_addr_a), 32'd19199);
        cyc(1, 480);
        cyc(2, 480);
        chk("vblank_addr_hold2", 32'(fb_addr_a), 32'd19199);

        // Test-pattern frame.
        fb_en = 1'b0;
        show(0, 0);
        chk("bar0", 32'(rgb_a), 32'hFF);
        chk("bar_cnt_2", 32'(fcnt_a), 32'd2);
        chk("bar_frame_addr0", 32'(fb_addr_a), 32'd0);
        show(128, 0);
        chk("bar1", 32'(rgb_a), 32'hFC);
        show(256, 0);
        chk("bar2", 32'(rgb_a), 32'h1F);
        show(384, 0);
        chk("bar3", 32'(rgb_a), 32'h1C);
        show(512, 0);
        chk("bar4", 32'(rgb_a), 32'hE3);
        show(600, 0);
        chk("bar4_b", 32'(rgb_b), 32'hE3);
        for (int h = 636; h < 668; h++) begin
            cyc(h, 0);
            if (h >= 639) begin
                chk("align_rgb_lat1", 32'(rgb_a), ((h - 3) < 640) ? 32'hE3 : 32'h00);
                chk("align_hs_lat1", 32'(hs_out_a),
                    ((h - 3) >= 656 && (h - 3) < 752) ? 32'h0 : 32'h1);
            end
            if (h >= 641) begin
                chk("align_rgb_lat3", 32'(rgb_b), ((h - 5) < 640) ? 32'hE3 : 32'h00);
                chk("align_hs_lat3", 32'(hs_out_b),
                    ((h - 5) >= 656 && (h - 5) < 752) ? 32'h0 : 32'h1);
            end
        end
        show(640, 0);
        chk("hblank_rgb", 32'(rgb_a), 32'h00);
        chk("hblank_fb_rd", 32'(fb_rd_a), 32'h0);
        show(100, 480);
        chk("vblank_rgb", 32'(rgb_a), 32'h00);
        chk("vblank_fb_rd2", 32'(fb_rd_a), 32'h0);
        chk("vblank_out", 32'(vb_out_a), 32'h1);
        show(0, 490);
        chk("vs_out_low", 32'(vs_out_a), 32'h0);

        // Mode change mid-frame takes effect only at the next frame start.
        fb_en = 1'b1;
        show(0, 0);
        chk("fb_frame_rgb0", 32'(rgb_a), 32'h00);
        chk("fb_frame_cnt3", 32'(fcnt_a), 32'd3);
        cyc(10, 200);
        fb_en = 1'b0;
        show(8, 200);
        chk("toggle_keep_fb", 32'(rgb_a), 32'h02);
        show(300, 200);
        chk("toggle_keep_fb2", 32'(rgb_a), 32'h4B);
        show(0, 0);
        chk("toggle_bars_next", 32'(rgb_a), 32'hFF);
        chk("toggle_cnt4", 32'(fcnt_a), 32'd4);
        for (int i = 0; i < 251; i++) begin
            cyc(0, 0);
            cyc(1, 0);
        end
        chk("cnt_255", 32'(fcnt_a), 32'd255);
        show(0, 0);
        chk("cnt_wrap", 32'(fcnt_a), 32'd0);

        // Asynchronous reset in the middle of a visible line.
        fb_en = 1'b1;
        show(0, 0);
        cyc(639, 3);
        cyc(640, 3);
        cyc(296, 100);
        cyc(297, 100);
        cyc(298, 100);
        cyc(299, 100);
        cyc(300, 100);
        chk("pre_rst_rgb", 32'(rgb_a), 32'hEA);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rgb", 32'(rgb_a), 32'h00);
        chk("mid_rst_fb_addr", 32'(fb_addr_a), 32'h0);
        chk("mid_rst_fb_rd", 32'(fb_rd_a), 32'h0);
        chk("mid_rst_hs", 32'(hs_out_a), 32'h1);
        chk("mid_rst_cnt", 32'(fcnt_a), 32'h0);
        cyc(301, 100);
        cyc(302, 100);
        cyc(303, 100);
        rst_n = 1'b1;
        cyc(304, 100);
        chk("post_rst_black1", 32'(rgb_a), 32'h00);
        chk("post_rst_fb_addr", 32'(fb_addr_a), 32'd75);
        cyc(305, 100);
        chk("post_rst_black2", 32'(rgb_a), 32'h00);
        cyc(306, 100);
        chk("post_rst_bars", 32'(rgb_a), 32'h1F);
        cyc(10, 480);
        cyc(11, 480);
        show(0, 0);
        chk("next_frame_addr", 32'(fb_addr_a), 32'd0);
        chk("next_frame_cnt", 32'(fcnt_a), 32'd1);
        show(4, 0);
        chk("next_frame_fb", 32'(rgb_a), 32'h01);
        chk("next_frame_addr2", 32'(fb_addr_a), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
